// File: rtl/frame_pkg.sv
// Shared framebuffer definitions: panel geometry defaults, arbiter state
// encoding and grant-type encoding for the SPRAM row arbiter.
package frame_pkg;

    localparam int ROWS_DEF = 4;
    localparam int COLS_DEF = 8;
    localparam int DW_DEF   = 16;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RD_BURST = 2'd1,
        ST_WR_BURST = 2'd2
    } arb_state_t;

    typedef enum logic {
        GRANT_RD = 1'b0,
        GRANT_WR = 1'b1
    } grant_t;

endpackage

// File: rtl/burst_addr_gen.sv
// Row latch plus column counter for one row burst. The column holds at its
// terminal value after the last access so the SPRAM address stays put in IDLE.
module burst_addr_gen #(
    parameter int ROWS = 4,
    parameter int COLS = 8,
    localparam int RB = $clog2(ROWS),
    localparam int CB = $clog2(COLS)
) (
    input  logic          fast_clk,
    input  logic          reset,
    input  logic          start,
    input  logic          advance,
    input  logic [RB-1:0] row_in,
    output logic [RB-1:0] row,
    output logic [CB-1:0] col,
    output logic          last
);

    logic [RB-1:0] row_reg;
    logic [CB-1:0] col_reg;

    always_ff @(posedge fast_clk or posedge reset) begin
        if (reset) begin
            row_reg <= '0;
            col_reg <= '0;
        end else if (start) begin
            row_reg <= row_in;
            col_reg <= '0;
        end else if (advance) begin
            col_reg <= col_reg + 1'b1;
        end
    end

    assign row  = row_reg;
    assign col  = col_reg;
    assign last = (col_reg == CB'(COLS - 1));

endmodule

// File: rtl/spram_row_arbiter.sv
// Row-burst arbiter sharing one single-port SPRAM between the scan reader and
// the pixel writer. Define SPRAM_ARB_RD_PRIORITY_EN for strict reader priority.
module spram_row_arbiter
    import frame_pkg::*;
#(
    parameter int ROWS = ROWS_DEF,
    parameter int COLS = COLS_DEF,
    parameter int DW   = DW_DEF,
    localparam int RB = $clog2(ROWS),
    localparam int CB = $clog2(COLS),
    localparam int AB = RB + CB
) (
    input  logic          fast_clk,
    input  logic          reset,
    input  logic          rd_req,
    input  logic [RB-1:0] rd_row,
    output logic          rd_ack,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic [CB-1:0] rd_col,
    output logic          rd_last,
    input  logic          wr_req,
    input  logic [RB-1:0] wr_row,
    output logic          wr_ack,
    output logic          wr_pull,
    output logic [CB-1:0] wr_col,
    input  logic [DW-1:0] wr_data,
    output logic [AB-1:0] spram_addr,
    output logic          spram_wren,
    output logic [DW-1:0] spram_wdata,
    input  logic [DW-1:0] spram_rdata
);

    arb_state_t    state_reg, state_next;
    grant_t        last_grant_reg, last_grant_next;
    logic          start;
    logic [RB-1:0] start_row;
    logic          advance;
    logic          tie_rd;
    logic [RB-1:0] row;
    logic [CB-1:0] col;
    logic          last;
    logic          in_rd, in_wr;
    logic          rd_valid_reg;
    logic [CB-1:0] rd_col_reg;
    logic          rd_last_reg;

`ifdef SPRAM_ARB_RD_PRIORITY_EN
    assign tie_rd = 1'b1;
`else
    assign tie_rd = (last_grant_reg == GRANT_WR);
`endif

    always_ff @(posedge fast_clk or posedge reset) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            last_grant_reg <= GRANT_WR;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        start           = 1'b0;
        start_row       = rd_row;
        case (state_reg)
            ST_IDLE: begin
                if (rd_req && (!wr_req || tie_rd)) begin
                    state_next      = ST_RD_BURST;
                    last_grant_next = GRANT_RD;
                    start           = 1'b1;
                    start_row       = rd_row;
                end else if (wr_req) begin
                    state_next      = ST_WR_BURST;
                    last_grant_next = GRANT_WR;
                    start           = 1'b1;
                    start_row       = wr_row;
                end
            end
            ST_RD_BURST, ST_WR_BURST: begin
                if (last) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign in_rd   = (state_reg == ST_RD_BURST);
    assign in_wr   = (state_reg == ST_WR_BURST);
    assign advance = (in_rd || in_wr) && !last;

    burst_addr_gen #(
        .ROWS(ROWS),
        .COLS(COLS)
    ) u_addr_gen (
        .fast_clk(fast_clk),
        .reset   (reset),
        .start   (start),
        .advance (advance),
        .row_in  (start_row),
        .row     (row),
        .col     (col),
        .last    (last)
    );

    // Read returns trail the issue by the SPRAM's one-cycle output register.
    always_ff @(posedge fast_clk or posedge reset) begin
        if (reset) begin
            rd_valid_reg <= 1'b0;
            rd_col_reg   <= '0;
            rd_last_reg  <= 1'b0;
        end else begin
            rd_valid_reg <= in_rd;
            rd_col_reg   <= col;
            rd_last_reg  <= in_rd && last;
        end
    end

    assign rd_ack      = in_rd && (col == '0);
    assign wr_ack      = in_wr && (col == '0);
    assign rd_valid    = rd_valid_reg;
    assign rd_col      = rd_col_reg;
    assign rd_last     = rd_last_reg;
    assign rd_data     = spram_rdata;
    assign wr_pull     = in_wr;
    assign wr_col      = col;
    assign spram_addr  = {row, col};
    assign spram_wren  = in_wr;
    assign spram_wdata = wr_data;

endmodule
